// File: rtl/hex_entry_unit.sv
// Operator hex-entry front end: debounced buttons shift switch nibbles into an
// entry register and hand the assembled word off over a valid/ready handshake.

module hex_entry_debounce #(
  parameter int CYCLES = 270000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic          state_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  // Synchronizer resets to the released level so a button held through reset
  // must complete a fresh debounce interval before it counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= 1'b0;
      state_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_n_i;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      state_prev_q <= state_q;
      cnt_q        <= cnt_d;
    end
  end

  assign pressed = ~sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (pressed == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CYCLES - 1)) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign press_o = state_q & ~state_prev_q;

endmodule

module hex_entry_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [3:0]                          nibble_i,
  input  logic                                enter_btn_n_i,
  input  logic                                submit_btn_n_i,
  input  logic                                clear_btn_n_i,
  output logic [DATA_WIDTH-1:0]               entry_value_o,
  output logic [$clog2(DATA_WIDTH/4+1)-1:0]   digit_count_o,
  output logic                                full_o,
  output logic [DATA_WIDTH-1:0]               data_out_o,
  output logic                                data_valid_o,
  input  logic                                data_ready_i
);

  localparam int DIGITS = DATA_WIDTH / 4;
  localparam int CNTW   = $clog2(DIGITS + 1);

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            nib1_q, nib2_q;
  logic [DATA_WIDTH-1:0] entry_q, entry_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  enter_p, submit_p, clear_p;
  logic                  full;

  hex_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_n_i (enter_btn_n_i),
    .press_o (enter_p)
  );

  hex_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_n_i (submit_btn_n_i),
    .press_o (submit_p)
  );

  hex_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_n_i (clear_btn_n_i),
    .press_o (clear_p)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_ENTRY;
      nib1_q   <= '0;
      nib2_q   <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nib1_q   <= nibble_i;
      nib2_q   <= nib1_q;
      entry_q  <= entry_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign full = (count_q == CNTW'(DIGITS));

  // One action per cycle: Clear beats Submit beats Enter; HOLD ignores buttons.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    case (state_q)
      ST_ENTRY: begin
        if (clear_p) begin
          entry_d = '0;
          count_d = '0;
        end else if (submit_p && (count_q != '0)) begin
          dout_d   = entry_q;
          dvalid_d = 1'b1;
          state_d  = ST_HOLD;
        end else if (enter_p && !full) begin
          entry_d = {entry_q[DATA_WIDTH-5:0], nib2_q};
          count_d = count_q + CNTW'(1);
        end
      end
      ST_HOLD: begin
        if (data_ready_i) begin
          dvalid_d = 1'b0;
          entry_d  = '0;
          count_d  = '0;
          state_d  = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  assign entry_value_o = entry_q;
  assign digit_count_o = count_q;
  assign full_o        = full;
  assign data_out_o    = dout_q;
  assign data_valid_o  = dvalid_q;

endmodule

// File: tb/tb_hex_entry_unit.sv
// Directed bench for hex_entry_unit: handoff words checked by a scoreboard
// monitor, entry-register state checked at fixed points in the stimulus.

module tb_hex_entry_unit;

  localparam int DW  = 32;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    nibble = 4'h0;
  logic          enter_n = 1'b1;
  logic          submit_n = 1'b1;
  logic          clear_n = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] entry;
  logic [3:0]    count;
  logic          full;
  logic [DW-1:0] dout;
  logic          dvalid;

  int vectors = 0;
  int miscompares = 0;
  int run_len = 0;
  int last_len = 0;
  logic [DW-1:0] exp_q[$];

  hex_entry_unit #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .nibble_i       (nibble),
    .enter_btn_n_i  (enter_n),
    .submit_btn_n_i (submit_n),
    .clear_btn_n_i  (clear_n),
    .entry_value_o  (entry),
    .digit_count_o  (count),
    .full_o         (full),
    .data_out_o     (dout),
    .data_valid_o   (dvalid),
    .data_ready_i   (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted handoff must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dvalid) begin
      run_len++;
      if (ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_handoff: got %h expected no transfer at %0t", dout, $time);
        end else begin
          chk("handoff_data", dout, exp_q.pop_front());
        end
      end
    end else if (run_len > 0) begin
      last_len = run_len;
      run_len  = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 with all buttons released and settled.
  task automatic press(input bit e, input bit s, input bit c, input int hold);
    if (e) enter_n = 1'b0;
    if (s) submit_n = 1'b0;
    if (c) clear_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    enter_n = 1'b1;
    submit_n = 1'b1;
    clear_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] n);
    nibble = n;
    press(1'b1, 1'b0, 1'b0, 8);
  endtask

  initial begin
    #2;
    chk("reset_entry", entry, 32'h0);
    chk("reset_count", {28'h0, count}, 32'h0);
    chk("reset_full", {31'h0, full}, 32'h0);
    chk("reset_valid", {31'h0, dvalid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Entry and handoff with consumer already ready
    enter_digit(4'h1);
    enter_digit(4'h2);
    enter_digit(4'h3);
    enter_digit(4'h4);
    chk("entry_1234", entry, 32'h0000_1234);
    chk("count_4", {28'h0, count}, 32'd4);
    ready = 1'b1;
    last_len = 0;
    exp_q.push_back(32'h0000_1234);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("valid_one_cycle", last_len, 32'd1);
    chk("dout_after_xfer", dout, 32'h0000_1234);
    chk("entry_cleared", entry, 32'h0);
    chk("count_cleared", {28'h0, count}, 32'h0);
    ready = 1'b0;

    // Overflow: ninth digit ignored
    for (int i = 1; i <= 8; i++) enter_digit(4'(i));
    chk("entry_full", entry, 32'h1234_5678);
    chk("count_8", {28'h0, count}, 32'd8);
    chk("full_high", {31'h0, full}, 32'h1);
    enter_digit(4'h9);
    chk("entry_no_wrap", entry, 32'h1234_5678);
    chk("count_stays_8", {28'h0, count}, 32'd8);
    press(1'b0, 1'b0, 1'b1, 8);
    chk("clear_after_full", entry, 32'h0);
    chk("full_low", {31'h0, full}, 32'h0);

    // Handshake hold: buttons ignored while the offer stands
    enter_digit(4'hC);
    enter_digit(4'hD);
    exp_q.push_back(32'h0000_00CD);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("hold_valid", {31'h0, dvalid}, 32'h1);
    chk("hold_dout", dout, 32'h0000_00CD);
    enter_digit(4'hE);
    press(1'b0, 1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("hold_valid_kept", {31'h0, dvalid}, 32'h1);
    chk("hold_dout_kept", dout, 32'h0000_00CD);
    chk("hold_entry_kept", entry, 32'h0000_00CD);
    chk("hold_count_kept", {28'h0, count}, 32'd2);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_done_valid", {31'h0, dvalid}, 32'h0);
    chk("hold_done_entry", entry, 32'h0);
    ready = 1'b0;

    // Debounce: 3-cycle glitch ignored, long press gives one digit on edge 7
    nibble = 4'h7;
    enter_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 enter_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_ignored", {28'h0, count}, 32'h0);
    enter_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("edge6_no_action", {28'h0, count}, 32'h0);
    @(posedge clk);
    #1;
    chk("edge7_count", {28'h0, count}, 32'd1);
    chk("edge7_entry", entry, 32'h7);
    repeat (93) @(posedge clk);
    #1 enter_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("long_press_once", {28'h0, count}, 32'd1);

    // Empty submit ignored; simultaneous buttons perform Clear only
    press(1'b0, 1'b0, 1'b1, 8);
    chk("cleared_for_empty", {28'h0, count}, 32'h0);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("empty_submit_valid", {31'h0, dvalid}, 32'h0);
    enter_digit(4'hA);
    enter_digit(4'hB);
    chk("entry_ab", entry, 32'h0000_00AB);
    press(1'b1, 1'b1, 1'b1, 8);
    chk("prio_entry", entry, 32'h0);
    chk("prio_count", {28'h0, count}, 32'h0);
    chk("prio_valid", {31'h0, dvalid}, 32'h0);

    // Asynchronous reset mid-HOLD and mid-debounce
    enter_digit(4'h3);
    enter_digit(4'h9);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("pre_reset_valid", {31'h0, dvalid}, 32'h1);
    chk("pre_reset_dout", dout, 32'h0000_0039);
    nibble = 4'h5;
    enter_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_entry", entry, 32'h0);
    chk("async_rst_count", {28'h0, count}, 32'h0);
    chk("async_rst_dout", dout, 32'h0);
    chk("async_rst_valid", {31'h0, dvalid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_early_pulse", {28'h0, count}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_fresh_press", {28'h0, count}, 32'd1);
    chk("post_rst_entry", entry, 32'h5);
    enter_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_single", {28'h0, count}, 32'd1);
    chk("post_rst_valid", {31'h0, dvalid}, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

endmodule
